patch_streamer: RTL

- Streaming successor to the single-patch vectoriser.
- Accepts an image raster one pixel per cycle over a valid/ready handshake and buffers one band of PATCH_SIZE rows.
- Emits every PATCH_SIZE x PATCH_SIZE patch of the band as one flattened vector over a second valid/ready handshake, then continues with the next band.
- Sits between the pixel source and the patch-embedding projection; supports pixel-interleaved and channel-planar flattening.

---
 rtl/patch_pkg.sv | 32 +++
 rtl/patch_band_buffer.sv | 43 ++++
 rtl/patch_streamer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/patch_pkg.sv
// Shared types and constants for the patch streamer.
//   state_e    : FSM encoding (StFill = 2'b00, StEmit = 2'b01), also driven out on the debug port
//   cnt_width  : counter width helper, never narrower than one bit
//   Def*       : default geometry and the constants derived from it
package patch_pkg;

  typedef enum logic [1:0] {
    StFill = 2'b00,
    StEmit = 2'b01
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DefChannelSize     = 8;
  localparam int unsigned DefNumChannels     = 3;
  localparam int unsigned DefPatchSize       = 4;
  localparam int unsigned DefImgW            = 16;
  localparam int unsigned DefImgH            = 16;

  localparam int unsigned DefPixelWidth       = DefChannelSize * DefNumChannels;
  localparam int unsigned DefPatchVectorSize  = DefPatchSize * DefPatchSize;
  localparam int unsigned DefNumPatches       = (DefImgW / DefPatchSize) * (DefImgH / DefPatchSize);

  localparam int unsigned DefRowW  = cnt_width(DefPatchSize);
  localparam int unsigned DefColW  = cnt_width(DefImgW);
  localparam int unsigned DefBandW = cnt_width(DefImgH / DefPatchSize);
  localparam int unsigned DefPcW   = cnt_width(DefImgW / DefPatchSize);
  localparam int unsigned DefIdxW  = cnt_width(DefNumPatches);

endpackage

// File: rtl/patch_band_buffer.sv
// Band buffer: PATCH_SIZE rows x IMG_W pixels, no reset (contents are always written before read).
//   clk      : clock
//   we       : write enable for wr_row/wr_col/wr_data
//   rd_pc    : patch column selecting the PATCH_SIZE x PATCH_SIZE window to read
//   rd_patch : combinational window, pixel (r,c) at element r*PATCH_SIZE+c, PIXEL_WIDTH bits each
module patch_band_buffer #(
  parameter int unsigned PIXEL_WIDTH = 24,
  parameter int unsigned PATCH_SIZE  = 4,
  parameter int unsigned IMG_W       = 16,
  parameter int unsigned ROW_W       = 2,
  parameter int unsigned COL_W       = 4,
  parameter int unsigned PC_W        = 2
) (
  input  logic                                      clk,
  input  logic                                      we,
  input  logic [ROW_W-1:0]                          wr_row,
  input  logic [COL_W-1:0]                          wr_col,
  input  logic [PIXEL_WIDTH-1:0]                    wr_data,
  input  logic [PC_W-1:0]                           rd_pc,
  output logic [PATCH_SIZE*PATCH_SIZE*PIXEL_WIDTH-1:0] rd_patch
);

  logic [PIXEL_WIDTH-1:0] mem [PATCH_SIZE][IMG_W];
  logic [COL_W-1:0]       col;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_row][wr_col] <= wr_data;
    end
  end

  always_comb begin
    rd_patch = '0;
    col      = '0;
    for (int r = 0; r < PATCH_SIZE; r++) begin
      for (int c = 0; c < PATCH_SIZE; c++) begin
        col = COL_W'(int'(rd_pc) * PATCH_SIZE + c);
        rd_patch[(r*PATCH_SIZE+c)*PIXEL_WIDTH +: PIXEL_WIDTH] = mem[r][col];
      end
    end
  end

endmodule

// File: rtl/patch_streamer.sv
// Streams a raster in one pixel per cycle, buffers one band of PATCH_SIZE rows and emits each
// PATCH_SIZE x PATCH_SIZE patch of the band as one flattened vector.
//   clk, reset     : clock, synchronous active-high reset
//   cfg_planar     : 0 pixel-interleaved, 1 channel-planar; latched on the first pixel of a frame
//   in_valid/ready : pixel handshake, in_pixel channel ch at [ch*CHANNEL_SIZE +: CHANNEL_SIZE]
//   out_valid/ready: patch handshake carrying out_patch, out_patch_idx and out_last
//   state          : FSM state for debug
module patch_streamer
  import patch_pkg::*;
#(
  parameter int unsigned CHANNEL_SIZE      = DefChannelSize,
  parameter int unsigned NUM_CHANNELS      = DefNumChannels,
  parameter int unsigned PIXEL_WIDTH       = CHANNEL_SIZE * NUM_CHANNELS,
  parameter int unsigned PATCH_SIZE        = DefPatchSize,
  parameter int unsigned IMG_W             = DefImgW,
  parameter int unsigned IMG_H             = DefImgH,
  parameter int unsigned PATCH_VECTOR_SIZE = PATCH_SIZE * PATCH_SIZE,
  parameter int unsigned NUM_PATCHES       = (IMG_W / PATCH_SIZE) * (IMG_H / PATCH_SIZE),
  parameter int unsigned IDX_W             = cnt_width(NUM_PATCHES)
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     cfg_planar,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [PIXEL_WIDTH-1:0]                   in_pixel,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [PATCH_VECTOR_SIZE*PIXEL_WIDTH-1:0] out_patch,
  output logic [IDX_W-1:0]                         out_patch_idx,
  output logic                                     out_last,
  output logic [1:0]                               state
);

  localparam int unsigned NumPc      = IMG_W / PATCH_SIZE;
  localparam int unsigned NumBands   = IMG_H / PATCH_SIZE;
  localparam int unsigned RowW       = cnt_width(PATCH_SIZE);
  localparam int unsigned ColW       = cnt_width(IMG_W);
  localparam int unsigned BandW      = cnt_width(NumBands);
  localparam int unsigned PcW        = cnt_width(NumPc);
  localparam int unsigned PatchBits  = PATCH_VECTOR_SIZE * PIXEL_WIDTH;

  state_e                state_q, state_d;
  logic [RowW-1:0]       row_q;
  logic [ColW-1:0]       col_q;
  logic [BandW-1:0]      band_q;
  logic [PcW-1:0]        pc_q;
  logic                  planar_q;
  logic                  out_valid_q;
  logic [PatchBits-1:0]  out_patch_q;
  logic [IDX_W-1:0]      out_idx_q;
  logic                  out_last_q;

  logic                  accept, load, take;
  logic                  last_pixel, first_pixel, pc_last;
  logic [IDX_W-1:0]      load_idx;
  logic [PatchBits-1:0]  raw_patch, flat_patch;

  assign in_ready    = (state_q == StFill);
  assign accept      = in_valid && in_ready;
  assign take        = out_valid_q && out_ready;
  assign load        = (state_q == StEmit) && (!out_valid_q || out_ready);
  assign last_pixel  = (row_q == RowW'(PATCH_SIZE - 1)) && (col_q == ColW'(IMG_W - 1));
  assign first_pixel = (band_q == '0) && (row_q == '0) && (col_q == '0);
  assign pc_last     = (pc_q == PcW'(NumPc - 1));
  assign load_idx    = IDX_W'(int'(band_q) * NumPc + int'(pc_q));

  patch_band_buffer #(
    .PIXEL_WIDTH (PIXEL_WIDTH),
    .PATCH_SIZE  (PATCH_SIZE),
    .IMG_W       (IMG_W),
    .ROW_W       (RowW),
    .COL_W       (ColW),
    .PC_W        (PcW)
  ) u_band_buffer (
    .clk      (clk),
    .we       (accept),
    .wr_row   (row_q),
    .wr_col   (col_q),
    .wr_data  (in_pixel),
    .rd_pc    (pc_q),
    .rd_patch (raw_patch)
  );

  // Planar mode regroups the interleaved window so each channel forms one contiguous block.
  always_comb begin
    flat_patch = raw_patch;
    if (planar_q) begin
      for (int k = 0; k < PATCH_VECTOR_SIZE; k++) begin
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
          flat_patch[(ch*PATCH_VECTOR_SIZE+k)*CHANNEL_SIZE +: CHANNEL_SIZE] =
              raw_patch[k*PIXEL_WIDTH+ch*CHANNEL_SIZE +: CHANNEL_SIZE];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFill: if (accept && last_pixel) state_d = StEmit;
      StEmit: if (load && pc_last) state_d = StFill;
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StFill;
      row_q       <= '0;
      col_q       <= '0;
      band_q      <= '0;
      pc_q        <= '0;
      planar_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_patch_q <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q <= state_d;

      if (accept) begin
        if (first_pixel) planar_q <= cfg_planar;
        if (col_q == ColW'(IMG_W - 1)) begin
          col_q <= '0;
          row_q <= (row_q == RowW'(PATCH_SIZE - 1)) ? '0 : row_q + RowW'(1);
        end else begin
          col_q <= col_q + ColW'(1);
        end
        if (last_pixel) pc_q <= '0;
      end

      // Load takes priority over a plain take so a consumed patch is replaced in the same cycle.
      if (load) begin
        out_valid_q <= 1'b1;
        out_patch_q <= flat_patch;
        out_idx_q   <= load_idx;
        out_last_q  <= (load_idx == IDX_W'(NUM_PATCHES - 1));
        pc_q        <= pc_last ? '0 : pc_q + PcW'(1);
        if (pc_last) begin
          band_q <= (band_q == BandW'(NumBands - 1)) ? '0 : band_q + BandW'(1);
        end
      end else if (take) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid     = out_valid_q;
  assign out_patch     = out_patch_q;
  assign out_patch_idx = out_idx_q;
  assign out_last      = out_last_q;
  assign state         = state_q;

endmodule
